// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8N1 UART receiver with start-bit qualification
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (rx),
    .q        (rx_s)
  );

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      frame_err  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_out;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        // A start bit that is high again at its centre was only a glitch.
        START: begin
          if (tick_q == TICK_HALF) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        // Hold here while the line stays low so a break is not read as 0x00 frames.
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk_in      = 1'b0;
  logic          rst_n_in    = 1'b0;
  logic          sample_tick = 1'b0;
  logic          rx          = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  int tick_div = 54;
  int tick_ph  = 0;
  int cyc      = 0;

  logic [DB-1:0] got_q[$];
  int            valid_cyc[$];
  int            ferr_cnt    = 0;
  int            collide_cnt = 0;
  logic [DB-1:0] model_data  = '0;

  // Tick source and output monitor share the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (data_valid) begin
        got_q.push_back(data_out);
        valid_cyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (data_valid && frame_err) collide_cnt++;
      tick_ph++;
      if (tick_ph >= tick_div) begin
        tick_ph     = 0;
        sample_tick = 1'b1;
      end else begin
        sample_tick = 1'b0;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk_in);
      while (!sample_tick) @(posedge clk_in);
    end
    @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = stop;
    wait_ticks(OS);
  endtask

  task automatic clear_monitor();
    got_q.delete();
    valid_cyc.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n_in = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_single_frame();
    clear_monitor();
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    model_data = 8'hA5;
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_valid_count got %0d want 1", got_q.size()); end
    n_cmp++; if (data_out !== model_data) begin n_bad++; $display("FAIL single_data_out got %h want %h", data_out, model_data); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL single_frame_err got %0d want 0", ferr_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int period;
    clear_monitor();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);
    model_data = 8'hFF;
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL b2b_valid_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      period = valid_cyc[1] - valid_cyc[0];
      n_cmp++; if (got_q[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_first got %h want 00", got_q[0]); end
      n_cmp++; if (got_q[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second got %h want ff", got_q[1]); end
      n_cmp++; if (period !== (DB + 2) * OS * tick_div) begin n_bad++; $display("FAIL b2b_period got %0d want %0d", period, (DB + 2) * OS * tick_div); end
    end
  endtask

  task automatic test_glitch();
    clear_monitor();
    rx = 1'b0;
    wait_ticks(3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_during got %b want 1", busy); end
    rx = 1'b1;
    wait_ticks(OS / 2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after got %b want 0", busy); end
    n_cmp++; if (got_q.size() !== 0 || ferr_cnt !== 0) begin n_bad++; $display("FAIL glitch_pulses got valid %0d ferr %0d want 0 0", got_q.size(), ferr_cnt); end
  endtask

  task automatic test_frame_err();
    clear_monitor();
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_held got %b want 1", busy); end
    n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL ferr_valid_count got %0d want 0", got_q.size()); end
    rx = 1'b1;
    wait_ticks(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    n_cmp++; if (data_out !== model_data) begin n_bad++; $display("FAIL ferr_data_out got %h want %h", data_out, model_data); end
  endtask

  task automatic test_random();
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] b;
    logic          stop;
    int            exp_ferr = 0;
    clear_monitor();
    for (int n = 0; n < 8; n++) begin
      b    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back(b);
        model_data = b;
      end else begin
        exp_ferr++;
        wait_ticks($urandom_range(1, 20));
        rx = 1'b1;
        wait_ticks(2);
      end
      wait_ticks($urandom_range(0, 12));
    end
    wait_ticks(4);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_valid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (ferr_cnt !== exp_ferr) begin n_bad++; $display("FAIL rand_ferr_count got %0d want %0d", ferr_cnt, exp_ferr); end
    n_cmp++; if (data_out !== model_data) begin n_bad++; $display("FAIL rand_data_out got %h want %h", data_out, model_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DB-1:0] b;
    b = 8'h5A;
    clear_monitor();
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = b[4];
    wait_ticks(OS / 2);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs got data %h valid %b ferr %b want 00 0 0", data_out, data_valid, frame_err);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    rx = 1'b1;
    model_data = '0;
    wait_ticks(2 * OS);
    n_cmp++; if (got_q.size() !== 0 || ferr_cnt !== 0) begin n_bad++; $display("FAIL midrst_aborted got valid %0d ferr %0d want 0 0", got_q.size(), ferr_cnt); end
    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    model_data = 8'h81;
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL midrst_valid_count got %0d want 1", got_q.size()); end
    n_cmp++; if (data_out !== model_data) begin n_bad++; $display("FAIL midrst_data_out got %h want %h", data_out, model_data); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    tick_div = 6;
    wait_ticks(2);
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random();
    test_reset_mid_frame();
    n_cmp++; if (collide_cnt !== 0) begin n_bad++; $display("FAIL valid_ferr_overlap got %0d want 0", collide_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
